// File: rtl/sram_burst_reader_if.sv
// sram_burst_reader_if: request, SRAM port and output stream bundle for the burst reader.
interface sram_burst_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 10,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [AW-1:0]         req_addr_i;
  logic [LEN_WIDTH-1:0]  req_len_i;
  logic                  sram_en_o;
  logic                  sram_we_o;
  logic [AW-1:0]         sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_data_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_last_o;
  logic                  busy_o;
  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, sram_data_i, m_ready_i,
    output req_ready_o, sram_en_o, sram_we_o, sram_addr_o, m_valid_o, m_data_o, m_last_o, busy_o
  );
  modport master (
    output req_valid_i, req_addr_i, req_len_i, sram_data_i, m_ready_i,
    input  req_ready_o, sram_en_o, sram_we_o, sram_addr_o, m_valid_o, m_data_o, m_last_o, busy_o
  );
endinterface

// File: rtl/sram_burst_reader.sv
// sram_burst_reader: streams a burst of consecutive SRAM words through a 2-entry FIFO,
// issuing reads only when the FIFO can absorb every outstanding word.
module sram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int N_ENTRIES  = 1024,
  parameter int LEN_WIDTH  = 8
) (
  input logic clk_i,
  input logic rst_ni,
  sram_burst_reader_if.slave bus
);
  localparam int AW = $clog2(N_ENTRIES);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t                state, state_nx;
  logic [AW-1:0]         addr;
  logic [LEN_WIDTH-1:0]  len, issue_cnt, pop_cnt;
  logic                  inflight, wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  accept, issue, pop, credit;
  assign pop    = bus.m_valid_o & bus.m_ready_i;
  assign accept = bus.req_valid_i & bus.req_ready_o;
  // a slot freed by this cycle's pop may be reused by the read issued now
  assign credit = ({1'b0, count} + 3'(inflight)) < (3'd2 + 3'(pop));
  assign issue  = (state == ISSUE) && credit;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE  && accept)                   ? ISSUE :
               (state == ISSUE && issue && issue_cnt == len) ? DRAIN :
               (state == DRAIN && pop && pop_cnt == len)     ? IDLE  : state;
  end
  always_comb begin
    bus.req_ready_o = rst_ni && (state == IDLE);
    bus.busy_o      = (state != IDLE);
    bus.sram_en_o   = issue;
    bus.sram_we_o   = 1'b0;
    bus.sram_addr_o = addr;
    bus.m_valid_o   = (count != 2'd0);
    bus.m_data_o    = fifo[rd_ptr];
    bus.m_last_o    = bus.m_valid_o && (pop_cnt == len);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr      <= '0;
      len       <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
    end else begin
      inflight <= issue;
      if (accept) begin
        addr      <= bus.req_addr_i;
        len       <= bus.req_len_i;
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        if (issue) begin
          addr      <= (addr == AW'(N_ENTRIES - 1)) ? '0 : addr + 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (pop) pop_cnt <= pop_cnt + 1'b1;
      end
      if (inflight) begin
        fifo[wr_ptr] <= bus.sram_data_i;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(inflight) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_sram_burst_reader.sv
// tb_sram_burst_reader: directed and randomized bursts checked against a queue model of the SRAM contents.
module tb_sram_burst_reader;
  localparam int DW = 32;
  localparam int N  = 1024;
  localparam int LW = 8;
  localparam int AW = $clog2(N);
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [DW-1:0] mem [N];
  always #5 clk_i = ~clk_i;
  sram_burst_reader_if #(.DATA_WIDTH(DW), .AW(AW), .LEN_WIDTH(LW)) bus ();
  sram_burst_reader #(.DATA_WIDTH(DW), .N_ENTRIES(N), .LEN_WIDTH(LW)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );
  always @(posedge clk_i) if (bus.sram_en_o) bus.sram_data_i <= mem[bus.sram_addr_o];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready_o, 0);
    chk({tag, "_sram_en"},   bus.sram_en_o,   0);
    chk({tag, "_sram_we"},   bus.sram_we_o,   0);
    chk({tag, "_sram_addr"}, bus.sram_addr_o, 0);
    chk({tag, "_m_valid"},   bus.m_valid_o,   0);
    chk({tag, "_m_data"},    bus.m_data_o,    0);
    chk({tag, "_m_last"},    bus.m_last_o,    0);
    chk({tag, "_busy"},      bus.busy_o,      0);
  endtask
  // mode 0: ready always 1, mode 1: ready 1,0,0,1 repeating, mode 2: random ready
  task automatic burst(input int addr, input int len, input int mode, input bit hold_valid, input int abort_at);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] pd = '0;
    logic          pl = 1'b0;
    bit            stalled = 0, done = 0, pop;
    int            issued = 0, popped = 0, cyc = 0, tog = 0, first_pop = -1, last_pop = -1;
    for (int k = 0; k <= len; k++) exp_q.push_back(mem[(addr + k) % N]);
    @(negedge clk_i);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = AW'(addr);
    bus.req_len_i   = LW'(len);
    bus.m_ready_i   = 1'b1;
    #1;
    chk("idle_req_ready", bus.req_ready_o, 1);
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_m_valid", bus.m_valid_o, 0);
    while (!done && cyc < 20 * (len + 1) + 20) begin
      @(negedge clk_i);
      cyc++;
      bus.req_valid_i = hold_valid;
      if (hold_valid) begin
        bus.req_addr_i = AW'($urandom);
        bus.req_len_i  = LW'($urandom);
      end
      bus.m_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? (tog % 4 == 0 || tog % 4 == 3) : 1'($urandom % 2);
      tog++;
      #1;
      pop = bus.m_valid_o && bus.m_ready_i;
      chk("busy", bus.busy_o, 1);
      chk("req_ready_low", bus.req_ready_o, 0);
      chk("outstanding_le_2", (issued - popped + int'(bus.sram_en_o) - int'(pop)) <= 2, 1);
      if (bus.sram_en_o) begin
        chk("rd_addr", bus.sram_addr_o, (addr + issued) % N);
        chk("rd_within_len", issued <= len, 1);
      end
      if (stalled) begin
        chk("hold_valid", bus.m_valid_o, 1);
        chk("hold_data", bus.m_data_o, pd);
        chk("hold_last", bus.m_last_o, pl);
      end
      if (!bus.m_valid_o) chk("last_without_valid", bus.m_last_o, 0);
      if (pop) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        chk("data", bus.m_data_o, exp_q[0]);
        chk("last", bus.m_last_o, exp_q.size() == 1);
        void'(exp_q.pop_front());
        popped++;
        done = (exp_q.size() == 0);
        if (popped == abort_at) begin
          rst_ni = 1'b0;
          bus.req_valid_i = 1'b0;
          #1;
          chk_all_zero("abort");
          repeat (2) @(negedge clk_i);
          rst_ni = 1'b1;
          #1;
          chk("abort_ready_first", bus.req_ready_o, 1);
          repeat (6) begin
            @(negedge clk_i);
            #1;
            chk("abort_m_valid", bus.m_valid_o, 0);
            chk("abort_busy", bus.busy_o, 0);
            chk("abort_req_ready", bus.req_ready_o, 1);
          end
          return;
        end
      end
      stalled = bus.m_valid_o && !bus.m_ready_i;
      pd = bus.m_data_o;
      pl = bus.m_last_o;
      if (bus.sram_en_o) issued++;
    end
    bus.req_valid_i = 1'b0;
    chk("burst_complete", done, 1);
    chk("reads_issued", issued, len + 1);
    if (mode == 0) chk("one_word_per_cycle", last_pop - first_pop, len);
  endtask
  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    bus.m_ready_i   = 1'b0;
    bus.sram_data_i = '0;
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    repeat (2) @(negedge clk_i);
    #1;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("ready_after_reset", bus.req_ready_o, 1);
    burst('h010, 3, 0, 0, -1);
    burst('h3FE, 3, 0, 0, -1);
    burst('h020, 7, 1, 0, -1);
    burst('h005, 0, 0, 0, -1);
    burst('h100, 2, 0, 0, -1);
    burst('h0C8, 5, 0, 1, -1);
    burst('h3F0, 255, 0, 0, -1);
    burst('h040, 15, 0, 0, 3);
    burst('h123, 1, 0, 0, -1);
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    repeat (10) burst(int'($urandom % N), int'($urandom % 40), 2, 1'($urandom % 2), -1);
    burst(int'($urandom % N), 255, 2, 1'b1, -1);
    burst(int'($urandom % N), 9, 1, 1'b0, -1);
    chk("sram_we_const", bus.sram_we_o, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
